// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: two-flop row sync, tick-based debounce, one strobed code per press, 1-clock strobe after accept tick.
// Auto-repeat while a key is held is compiled in only when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8,
  parameter int REPEAT_TICKS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [4:0] keyout,
  output logic       key_held,
  output logic       multi_key_err
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_PRESSED  = 2'd2;

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_TICKS < 1) begin : g_param_check
    $error("keypad_scanner: illegal parameter value");
  end

  logic [3:0]       r_sync1;
  logic [3:0]       r_rows_s;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_state;
  logic [1:0]       r_col;
  logic [1:0]       r_cap_row;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_code;
  logic             r_stb;
  logic             r_held;
  logic             r_merr;

  logic       w_tick;
  logic       w_none;
  logic       w_single;
  logic [1:0] w_row_idx;
  logic       w_accept;
  logic [3:0] w_acc_code;
  logic       w_rep_stb;

  assign w_tick        = (r_div == DIV_LAST);
  assign col_o         = ~(4'b0001 << r_col);
  assign keyout        = {r_stb, r_code};
  assign key_held      = r_held;
  assign multi_key_err = r_merr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 4'hF;
      r_rows_s <= 4'hF;
      r_div    <= '0;
    end else begin
      r_sync1  <= row_i;
      r_rows_s <= r_sync1;
      r_div    <= w_tick ? '0 : r_div + 1'b1;
    end
  end

  always_comb begin
    w_none    = 1'b0;
    w_single  = 1'b1;
    w_row_idx = 2'd0;
    case (r_rows_s)
      4'b1111: begin w_none = 1'b1; w_single = 1'b0; end
      4'b1110: w_row_idx = 2'd0;
      4'b1101: w_row_idx = 2'd1;
      4'b1011: w_row_idx = 2'd2;
      4'b0111: w_row_idx = 2'd3;
      default: w_single = 1'b0;
    endcase
  end

  // With a single-tick debounce the press is accepted straight out of SCAN.
  always_comb begin
    w_accept   = 1'b0;
    w_acc_code = {r_cap_row, r_col};
    if (w_tick && w_single) begin
      if (r_state == S_SCAN && DEBOUNCE_CNT == 1) begin
        w_accept   = 1'b1;
        w_acc_code = {w_row_idx, r_col};
      end else if (r_state == S_DEBOUNCE && w_row_idx == r_cap_row && r_cnt == CNT_LAST) begin
        w_accept = 1'b1;
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_TICKS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);

  logic [REP_W-1:0] r_rep;
  logic             w_same_key;

  assign w_same_key = w_single && (w_row_idx == r_cap_row);
  assign w_rep_stb  = w_tick && (r_state == S_PRESSED) && w_same_key && (r_rep == REP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep <= '0;
    end else if (w_tick) begin
      if (r_state != S_PRESSED || w_none) begin
        r_rep <= '0;
      end else if (w_same_key) begin
        r_rep <= w_rep_stb ? '0 : r_rep + 1'b1;
      end
    end
  end
`else
  assign w_rep_stb = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_SCAN;
      r_col     <= 2'd0;
      r_cap_row <= 2'd0;
      r_cnt     <= '0;
      r_code    <= 4'd0;
      r_stb     <= 1'b0;
      r_held    <= 1'b0;
      r_merr    <= 1'b0;
    end else begin
      r_stb  <= w_accept | w_rep_stb;
      r_merr <= w_tick && !w_none && !w_single;
      if (w_accept) begin
        r_code <= w_acc_code;
      end
      if (w_tick) begin
        case (r_state)
          S_SCAN: begin
            if (w_single) begin
              r_cap_row <= w_row_idx;
              if (w_accept) begin
                r_cnt   <= '0;
                r_held  <= 1'b1;
                r_state <= S_PRESSED;
              end else begin
                r_cnt   <= CNT_W'(1);
                r_state <= S_DEBOUNCE;
              end
            end else begin
              r_col <= r_col + 2'd1;
            end
          end
          S_DEBOUNCE: begin
            if (w_accept) begin
              r_cnt   <= '0;
              r_held  <= 1'b1;
              r_state <= S_PRESSED;
            end else if (w_single && w_row_idx == r_cap_row) begin
              r_cnt <= r_cnt + 1'b1;
            end else begin
              r_cnt   <= '0;
              r_col   <= r_col + 2'd1;
              r_state <= S_SCAN;
            end
          end
          S_PRESSED: begin
            // Column stays parked here, so keys in other columns are invisible until release.
            if (!w_none) begin
              r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
              r_cnt   <= '0;
              r_held  <= 1'b0;
              r_col   <= r_col + 2'd1;
              r_state <= S_SCAN;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_cnt   <= '0;
            r_state <= S_SCAN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad driving row_i from col_o.
// SCAN_DIV=4, DEBOUNCE_CNT=3; repeat expectations switch on KEYPAD_REPEAT_EN.
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int REPEAT_TICKS = 4;
`ifdef KEYPAD_REPEAT_EN
  localparam int CLEAN_EXP = 2;
  localparam int LONG_EXP  = 5;
`else
  localparam int CLEAN_EXP = 1;
  localparam int LONG_EXP  = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [4:0] keyout;
  logic       key_held;
  logic       multi_key_err;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .row_i        (row_i),
    .col_o        (col_o),
    .keyout       (keyout),
    .key_held     (key_held),
    .multi_key_err(multi_key_err)
  );

  // Keypad model: a pressed key pulls its row low only while its column is driven.
  logic       k_down = 1'b0;
  logic [1:0] k_row = 2'd0;
  logic [1:0] k_col = 2'd0;
  logic       f_en = 1'b0;
  logic [3:0] f_rows = 4'hF;

  always_comb begin
    if (f_en) row_i = f_rows;
    else if (k_down && !col_o[k_col]) row_i = ~(4'b0001 << k_row);
    else row_i = 4'hF;
  end

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  int         n_strobe = 0;
  int         n_merr = 0;
  int         dbl_strobe = 0;
  int         hold_viol = 0;
  logic       prev_stb = 1'b0;
  logic       have_code = 1'b0;
  logic [3:0] last_code = 4'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stb  = 1'b0;
      have_code = 1'b0;
    end else begin
      if (keyout[4]) begin
        n_strobe++;
        if (prev_stb) dbl_strobe++;
        last_code = keyout[3:0];
        have_code = 1'b1;
      end else if (have_code && keyout[3:0] != last_code) begin
        hold_viol++;
      end
      if (multi_key_err) n_merr++;
      prev_stb = keyout[4];
    end
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic align_col(input logic [3:0] target, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      step(1);
      ok = (cyc % 4 == 0) && (col_o == target);
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_strobe(input int base, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      step(1);
      ok = (n_strobe > base);
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_release(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step(1);
      ok = !key_held;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    logic [3:0] ec;
    logic [3:0] prev;
    logic [3:0] seq [8];
    int s0;
    int m0;
    seq = '{4'h0, 4'h5, 4'hA, 4'hF, 4'h3, 4'hC, 4'h6, 4'h9};

    // Reset state and free-running column scan
    step(3);
    chk("rst_col", 32'(col_o), 32'h0E);
    chk("rst_keyout", 32'(keyout), 32'h00);
    chk("rst_held", 32'(key_held), 32'd0);
    chk("rst_merr", 32'(multi_key_err), 32'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      if (k % 4 == 0 || k == 3) begin
        ec = ~(4'b0001 << ((k / 4) % 4));
        chk($sformatf("scan_col_k%0d", k), 32'(col_o), 32'(ec));
      end
    end

    // Clean press row 2 col 1
    k_row = 2'd2; k_col = 2'd1;
    align_col(4'b1101, "clean_align");
    s0 = n_strobe;
    k_down = 1'b1;
    step(11);
    chk("clean_pre_strobe", 32'(keyout[4]), 32'd0);
    step(1);
    chk("clean_keyout", 32'(keyout), 32'h19);
    chk("clean_held_rise", 32'(key_held), 32'd1);
    step(1);
    chk("clean_strobe_1clk", 32'(keyout[4]), 32'd0);
    step(27);
    k_down = 1'b0;
    step(11);
    chk("clean_held_before_rel", 32'(key_held), 32'd1);
    chk("clean_col_parked", 32'(col_o), 32'h0D);
    step(1);
    chk("clean_held_fall", 32'(key_held), 32'd0);
    chk("clean_col_advance", 32'(col_o), 32'h0B);
    chk("clean_strobe_count", 32'(n_strobe - s0), 32'(CLEAN_EXP));

    // Bounce: row 2 low/high per tick five times, then stable
    align_col(4'b1101, "bounce_align");
    s0 = n_strobe;
    f_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      f_rows = 4'b1011;
      step(4);
      f_rows = 4'hF;
      step(4);
    end
    f_rows = 4'b1011;
    step(11);
    chk("bounce_no_strobe", 32'(n_strobe - s0), 32'd0);
    step(1);
    chk("bounce_keyout", 32'(keyout), 32'h1A);
    f_en = 1'b0;
    f_rows = 4'hF;
    step(16);
    chk("bounce_released", 32'(key_held), 32'd0);
    chk("bounce_strobe_count", 32'(n_strobe - s0), 32'd1);

    // Two rows low during one dwell
    for (int i = 0; i < 8 && (cyc % 4 != 0); i++) step(1);
    prev = col_o;
    s0 = n_strobe;
    m0 = n_merr;
    f_en = 1'b1;
    f_rows = 4'b1100;
    step(3);
    chk("multi_pre", 32'(multi_key_err), 32'd0);
    step(1);
    chk("multi_pulse", 32'(multi_key_err), 32'd1);
    ec = {prev[2:0], prev[3]};
    chk("multi_col_adv", 32'(col_o), 32'(ec));
    f_en = 1'b0;
    f_rows = 4'hF;
    step(1);
    chk("multi_pulse_end", 32'(multi_key_err), 32'd0);
    step(3);
    ec = {prev[1:0], prev[3:2]};
    chk("multi_scan_cont", 32'(col_o), 32'(ec));
    step(8);
    chk("multi_count", 32'(n_merr - m0), 32'd1);
    chk("multi_no_strobe", 32'(n_strobe - s0), 32'd0);

    // Eight-key sequence
    for (int i = 0; i < 8; i++) begin
      k_row = seq[i][3:2];
      k_col = seq[i][1:0];
      s0 = n_strobe;
      k_down = 1'b1;
      wait_strobe(s0, $sformatf("seq%0d_strobe", i));
      chk($sformatf("seq%0d_code", i), 32'(keyout[3:0]), 32'(seq[i]));
      k_down = 1'b0;
      wait_release($sformatf("seq%0d_release", i));
      step(2);
      chk($sformatf("seq%0d_hold", i), 32'(keyout[3:0]), 32'(seq[i]));
      chk($sformatf("seq%0d_count", i), 32'(n_strobe - s0), 32'd1);
    end

    // Reset pulse after two matching ticks aborts the press
    k_row = 2'd1; k_col = 2'd3;
    align_col(4'b0111, "rstdb_align");
    s0 = n_strobe;
    k_down = 1'b1;
    step(9);
    rst_n = 1'b0;
    step(1);
    chk("rstdb_col", 32'(col_o), 32'h0E);
    chk("rstdb_keyout", 32'(keyout), 32'h00);
    chk("rstdb_held", 32'(key_held), 32'd0);
    k_down = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(20);
    chk("rstdb_no_strobe", 32'(n_strobe - s0), 32'd0);
    chk("rstdb_scan", 32'(col_o), 32'h0D);

    // Long hold: one strobe, or repeats every REPEAT_TICKS when enabled
    k_row = 2'd0; k_col = 2'd2;
    align_col(4'b1011, "long_align");
    s0 = n_strobe;
    k_down = 1'b1;
    step(80);
    chk("long_code", 32'(keyout[3:0]), 32'h2);
    k_down = 1'b0;
    step(20);
    chk("long_strobe_count", 32'(n_strobe - s0), 32'(LONG_EXP));
    chk("long_released", 32'(key_held), 32'd0);

    chk("no_double_strobe", 32'(dbl_strobe), 32'd0);
    chk("code_stable", 32'(hold_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage of the door-lock sequence FSM.
- Scans a 4x4 active-low matrix keypad, synchronises and debounces the row inputs, and encodes one key press per physical press.
- Emits that press as a 5-bit keyout word: bit 4 is a one-cycle valid strobe, bits 3:0 are the key code.
- The FSM compares keyout[3:0] against its stored sequence nibble.

Parameters:
- SCAN_DIV, 1000, clocks per column dwell; rows are sampled on the last clock of each dwell (a "tick"); must be >= 4.
- DEBOUNCE_CNT, 8, number of consecutive identical ticks needed to accept a press and to accept a release; must be >= 1.
- REPEAT_TICKS, 64, auto-repeat interval in ticks; used only when KEYPAD_REPEAT_EN is defined.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- row_i  in  4  keypad rows, active-low (board pull-ups), asynchronous to clk
- col_o  out  4  keypad column drive, active-low, exactly one bit low at all times
- keyout  out  5  [4] one-cycle key strobe, [3:0] key code = {row_idx[1:0], col_idx[1:0]}
- key_held  out  1  high while an accepted key is still pressed
- multi_key_err  out  1  one-cycle pulse when more than one row is low on a tick

Behaviour:
- Reset (async, rst_n=0):
  - state=SCAN, col_idx=0, col_o=4'b1110.
  - Divider, debounce counter and synchroniser cleared to idle (rows high).
  - keyout=5'b0, key_held=0, multi_key_err=0.
  - Asserting reset mid-operation aborts any press; no strobe is emitted.
- Synchroniser: row_i passes through two flops before any use (rows_s). Edge-on-tick latency is 2 clocks; the SCAN_DIV >= 4 rule guarantees settling within a dwell.
- Divider: counts 0..SCAN_DIV-1 and wraps. A tick occurs when the divider equals SCAN_DIV-1. All state decisions happen only on ticks.
- Row decode on a tick:
  - none = rows_s == 4'hF.
  - single = exactly one bit low; row_idx is the index of that bit.
  - multi = two or more bits low.
- SCAN:
  - On tick with none: col_idx increments mod 4 and col_o follows.
  - On tick with multi: pulse multi_key_err and advance the column.
  - On tick with single: capture code={row_idx,col_idx}, set cnt=1, hold the column. If DEBOUNCE_CNT==1, accept immediately (see below); otherwise go to DEBOUNCE.
- DEBOUNCE (column held):
  - On tick with single and the same row: cnt++. When cnt reaches DEBOUNCE_CNT, accept.
  - Any other tick result: cnt=0, advance the column, return to SCAN. No strobe.
- Accept:
  - On the clock after the accepting tick, keyout[3:0]=code and keyout[4]=1 for exactly one clock.
  - Go to PRESSED, key_held=1, cnt=0.
- PRESSED (column held):
  - On tick with none: cnt++.
  - On tick with single or multi: cnt=0.
  - When cnt reaches DEBOUNCE_CNT: key_held=0, advance the column, go to SCAN.
  - A second key in another column is ignored until release.
- keyout[3:0] holds the last accepted code until the next accept. keyout[4] is never high two consecutive clocks.
- Column wrap: col_idx 3 -> 0 (col_o 4'b0111 -> 4'b1110).

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In PRESSED, a repeat counter runs on ticks from the accept.
  - Every REPEAT_TICKS ticks with the key still single/same, re-pulse keyout[4] with the same code.
  - Counter clears on any release tick.
- Undefined: exactly one strobe per press regardless of hold time; no repeat counter logic is present.

Test Plan (bench uses SCAN_DIV=4, DEBOUNCE_CNT=3):
- Reset: hold rst_n=0 -> col_o=4'b1110, keyout=0, key_held=0. Release reset with no keys -> col_o cycles 1110,1101,1011,0111,1110, changing every 4 clocks.
- Clean press of row 2, col 1 (row_i=4'b1011 while col_o=4'b1101), held 40 clocks -> exactly one keyout=5'b1_1001 pulse, on the clock after the 3rd matching tick. key_held rises with it and falls 3 release ticks after row_i returns to 4'hF.
- Bounce: row low for 1 tick, high for 1 tick, repeated 5 times, then stable -> no strobe during the bounce; a single strobe after 3 stable ticks.
- Two rows low (row_i=4'b1100) during a column dwell -> multi_key_err pulses for 1 clock, no strobe, scanning continues.
- Eight-key sequence entered one key at a time -> 8 strobes with codes in order, each code held stable on keyout[3:0] between strobes.
- rst_n pulsed low during DEBOUNCE (after 2 matching ticks) -> no strobe; state returns to SCAN with col_o=4'b1110. With KEYPAD_REPEAT_EN and REPEAT_TICKS=4, holding the key for 20 ticks -> initial strobe plus a repeat every 4 ticks.
